// File: rtl/hamming_dec_engine.sv
// hamming_dec_engine: memory-side SECDED decoder. Walks N_WORDS encoded 16-bit words from
// SRC_BASE, corrects single errors, flags double errors, and writes the 11-bit message plus
// a 2-bit flag field to DST_BASE. It shares the data-memory port with the core.
module hamming_dec_engine #(
  parameter int unsigned SRC_BASE = 30,
  parameter int unsigned DST_BASE = 0,
  parameter int unsigned N_WORDS  = 15,
  parameter int unsigned AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic [5:0]    n_single,
  output logic [5:0]    n_double
);

  typedef enum logic [2:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StFix,
    StWrLo,
    StWrHi,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    out_lo_q, out_lo_d;
  logic [7:0]    out_hi_q, out_hi_d;
  logic [5:0]    n_single_q, n_single_d;
  logic [5:0]    n_double_q, n_double_d;
  logic          done_q, done_d;

  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [15:0]   word;
  logic [15:0]   fixed;
  logic [3:0]    syn;
  logic          par;
  logic [1:0]    flags;
  logic [7:0]    dec_lo;
  logic [7:0]    dec_hi;
  logic          last;

  // Byte addresses of the current word; arithmetic wraps modulo 2^AW.
  assign src_addr = AW'(SRC_BASE) + AW'({idx_q, 1'b0});
  assign dst_addr = AW'(DST_BASE) + AW'({idx_q, 1'b0});
  assign last     = (idx_q == 6'(N_WORDS - 1));

  // Syndrome/parity check and correction of the latched word.
  always_comb begin
    word = {hi_q, lo_q};
    syn  = '0;
    for (int b = 1; b < 16; b++) begin
      if (word[b]) begin
        syn = syn ^ 4'(b);
      end
    end
    par   = ^word;
    fixed = word;
    // Odd overall parity means one flipped bit; syndrome 0 points at p0 itself.
    if (par) begin
      fixed[syn] = ~word[syn];
    end
    if (par) begin
      flags = 2'b01;
    end else if (syn != 4'd0) begin
      flags = 2'b10;
    end else begin
      flags = 2'b00;
    end
    dec_lo = {fixed[12], fixed[11], fixed[10], fixed[9], fixed[7], fixed[6], fixed[5], fixed[3]};
    dec_hi = {flags, 3'b000, fixed[15], fixed[14], fixed[13]};
  end

  // Next-state and memory-port outputs; the port idles at address 0.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    out_lo_d    = out_lo_q;
    out_hi_d    = out_hi_q;
    n_single_d  = n_single_q;
    n_double_d  = n_double_q;
    done_d      = done_q;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StRdLo;
          idx_d      = '0;
          n_single_d = '0;
          n_double_d = '0;
          done_d     = 1'b0;
        end
      end
      StRdLo: begin
        mem_addr = src_addr;
        lo_d     = mem_rd_data;
        state_d  = StRdHi;
      end
      StRdHi: begin
        mem_addr = src_addr + AW'(1);
        hi_d     = mem_rd_data;
        state_d  = StFix;
      end
      StFix: begin
        out_lo_d = dec_lo;
        out_hi_d = dec_hi;
        if (flags == 2'b01 && n_single_q != 6'd63) begin
          n_single_d = n_single_q + 6'd1;
        end
        if (flags == 2'b10 && n_double_q != 6'd63) begin
          n_double_d = n_double_q + 6'd1;
        end
        state_d = StWrLo;
      end
      StWrLo: begin
        mem_addr    = dst_addr;
        mem_wr_en   = 1'b1;
        mem_wr_data = out_lo_q;
        state_d     = StWrHi;
      end
      StWrHi: begin
        mem_addr    = dst_addr + AW'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = out_hi_q;
        if (last) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 6'd1;
          state_d = StRdLo;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      out_lo_q   <= '0;
      out_hi_q   <= '0;
      n_single_q <= '0;
      n_double_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      out_lo_q   <= out_lo_d;
      out_hi_q   <= out_hi_d;
      n_single_q <= n_single_d;
      n_double_q <= n_double_d;
      done_q     <= done_d;
    end
  end

  assign done     = done_q;
  assign n_single = n_single_q;
  assign n_double = n_double_q;

endmodule

// File: tb/tb_hamming_dec_engine.sv
// tb_hamming_dec_engine: scoreboard bench. Loading a source word pushes its expected
// destination writes; a monitor per engine pops and compares on every write strobe.
module tb_hamming_dec_engine;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter engine.
  logic       start0, done0, wr0;
  logic [7:0] addr0, rd0, wd0;
  logic [5:0] ns0, nd0;
  logic [7:0] mem0 [256];

  // Overridden-parameter engine.
  logic       start1, done1, wr1;
  logic [7:0] addr1, rd1, wd1;
  logic [5:0] ns1, nd1;
  logic [7:0] mem1 [256];

  hamming_dec_engine dut0 (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start0),
    .done       (done0),
    .mem_addr   (addr0),
    .mem_rd_data(rd0),
    .mem_wr_en  (wr0),
    .mem_wr_data(wd0),
    .n_single   (ns0),
    .n_double   (nd0)
  );

  hamming_dec_engine #(
    .SRC_BASE(64),
    .DST_BASE(128),
    .N_WORDS (1),
    .AW      (8)
  ) dut1 (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start1),
    .done       (done1),
    .mem_addr   (addr1),
    .mem_rd_data(rd1),
    .mem_wr_en  (wr1),
    .mem_wr_data(wd1),
    .n_single   (ns1),
    .n_double   (nd1)
  );

  assign rd0 = mem0[addr0];
  assign rd1 = mem1[addr1];

  always @(posedge clk) if (wr0) mem0[addr0] = wd0;
  always @(posedge clk) if (wr1) mem1[addr1] = wd1;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt0  = 0;
  int wr_cnt1  = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the default engine.
  always @(negedge clk) begin
    logic [15:0] e;
    if (wr0) begin
      wr_cnt0++;
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr0_unexpected: write addr 0x%0h data 0x%0h, none expected", addr0, wd0);
      end else begin
        e = q0.pop_front();
        check("wr0_addr", addr0, e[15:8]);
        check("wr0_data", wd0, e[7:0]);
      end
    end
  end

  // Scoreboard monitor for the overridden engine.
  always @(negedge clk) begin
    logic [15:0] e;
    if (wr1) begin
      wr_cnt1++;
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr1_unexpected: write addr 0x%0h data 0x%0h, none expected", addr1, wd1);
      end else begin
        e = q1.pop_front();
        check("wr1_addr", addr1, e[15:8]);
        check("wr1_data", wd1, e[7:0]);
      end
    end
  end

  // Mixed vectors: encoded word, expected high byte, expected low byte (hand-decoded).
  logic [15:0] mix_w  [15] = '{16'h55A5, 16'hFFFF, 16'h0000, 16'h57AD, 16'hFFBF,
                               16'h2000, 16'hFFF9, 16'h1020, 16'h55A4, 16'h55A5,
                               16'h0001, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h57AD};
  logic [7:0]  mix_hi [15] = '{8'h02, 8'h07, 8'h00, 8'h82, 8'h47,
                               8'h40, 8'h87, 8'h80, 8'h42, 8'h02,
                               8'h40, 8'h07, 8'h47, 8'h00, 8'h82};
  logic [7:0]  mix_lo [15] = '{8'hAA, 8'hFF, 8'h00, 8'hBB, 8'hFF,
                               8'h00, 8'hFF, 8'h82, 8'hAA, 8'hAA,
                               8'h00, 8'hFF, 8'hFF, 8'h00, 8'hBB};

  task automatic load_word0(input int i, input logic [15:0] w, input logic [7:0] hi,
                            input logic [7:0] lo, input bit push);
    mem0[30 + 2 * i] = w[7:0];
    mem0[31 + 2 * i] = w[15:8];
    if (push) begin
      q0.push_back({8'(2 * i), lo});
      q0.push_back({8'(2 * i + 1), hi});
    end
  endtask

  task automatic load_mixed(input int n_push);
    for (int i = 0; i < 15; i++) load_word0(i, mix_w[i], mix_hi[i], mix_lo[i], i < n_push);
  endtask

  // Start one run on engine 0; optionally pulse start again at a given edge count.
  task automatic run0(input int pulse_at, output int cycles);
    @(posedge clk);
    #1 start0 = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk);
      cycles++;
      #1;
      start0 = (cycles == pulse_at);
    end while (!done0 && cycles < 300);
    start0 = 1'b0;
    if (!done0) check("done0_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    int base;
    int bad;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'hEE;
      mem1[i] = 8'hEE;
    end
    #12;
    check("rst_done", done0, 0);
    check("rst_wr_en", wr0, 0);
    check("rst_addr", addr0, 0);
    check("rst_wr_data", wd0, 0);
    check("rst_n_single", ns0, 0);
    check("rst_n_double", nd0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Clean run.
    for (int i = 0; i < 15; i++) load_word0(i, 16'h55A5, 8'h02, 8'hAA, 1'b1);
    base = wr_cnt0;
    run0(0, cyc);
    check("clean_done_cycles", cyc, 76);
    check("clean_n_single", ns0, 0);
    check("clean_n_double", nd0, 0);
    check("clean_writes", wr_cnt0 - base, 30);
    check("clean_addr_idle", addr0, 0);

    // Single error at each position 0..14.
    for (int i = 0; i < 15; i++) load_word0(i, 16'h55A5 ^ (16'h0001 << i), 8'h42, 8'hAA, 1'b1);
    run0(0, cyc);
    check("single_done_cycles", cyc, 76);
    check("single_n_single", ns0, 15);
    check("single_n_double", nd0, 0);

    // Mixed clean / single / double.
    load_mixed(15);
    run0(0, cyc);
    check("mixed_n_single", ns0, 5);
    check("mixed_n_double", nd0, 4);
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (mem0[30 + 2 * i] !== mix_w[i][7:0] || mem0[31 + 2 * i] !== mix_w[i][15:8]) bad++;
    end
    check("mixed_src_unchanged", bad, 0);

    // start pulsed mid-run is ignored.
    load_mixed(15);
    base = wr_cnt0;
    run0(10, cyc);
    check("pulse_done_cycles", cyc, 76);
    check("pulse_writes", wr_cnt0 - base, 30);
    check("pulse_n_single", ns0, 5);

    // Reset mid-run: four words complete before reset lands in word 4.
    load_mixed(4);
    base = wr_cnt0;
    @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_done", done0, 0);
    check("rstmid_wr_en", wr0, 0);
    check("rstmid_addr", addr0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rstmid_writes", wr_cnt0 - base, 8);
    check("rstmid_queue_left", q0.size(), 0);
    check("rstmid_n_double", nd0, 0);
    load_mixed(15);
    run0(0, cyc);
    check("rerun_done_cycles", cyc, 76);
    check("rerun_n_single", ns0, 5);
    check("rerun_n_double", nd0, 4);

    // Overridden engine: one double-error word at 64, output at 128/129.
    mem1[64] = 8'hAD;
    mem1[65] = 8'h57;
    q1.push_back({8'd128, 8'hBB});
    q1.push_back({8'd129, 8'h82});
    @(posedge clk);
    #1 start1 = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      #1 start1 = 1'b0;
    end while (!done1 && cyc < 50);
    check("ovr_done_cycles", cyc, 6);
    check("ovr_n_double", nd1, 1);
    check("ovr_n_single", ns1, 0);
    check("ovr_writes", wr_cnt1, 2);
    check("ovr_queue_left", q1.size(), 0);

    repeat (3) @(posedge clk);
    check("final_queue_left", q0.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_dec_engine.md
# hamming_dec_engine

Hardware SECDED decode stage that consumes the Hamming-encoded 16-bit words produced by the program 1 encoder and stored in data memory. On `start`, it walks `N_WORDS` encoded words from `SRC_BASE` and checks and corrects each one. It writes the 11-bit message plus a 2-bit error flag to `DST_BASE`, then raises `done`. It is a memory-side engine that shares the data-memory port with the core, which must stay idle while the engine is busy.

## Interface
- `SRC_BASE`, default 30: byte address of the first encoded word (low byte; high byte at +1).
- `DST_BASE`, default 0: byte address of the first decoded output (low byte; high byte at +1).
- `N_WORDS`, default 15: number of words processed per run (1..63).
- `AW`, default 8: memory address width.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low; clears all state immediately.
- `start`, input, 1: run request, sampled only in IDLE.
- `done`, output, 1: run complete; held high until the next accepted `start`.
- `mem_addr`, output, AW: memory byte address.
- `mem_rd_data`, input, 8: combinational read data for `mem_addr`, valid in the same cycle.
- `mem_wr_en`, output, 1: write strobe; memory writes `mem_wr_data` at `mem_addr` on the rising edge.
- `mem_wr_data`, output, 8: write data.
- `n_single`, output, 6: count of corrected words in the current or last run.
- `n_double`, output, 6: count of double-error words in the current or last run.

## Operation
- Encoded word bit i equals Hamming position i: {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}. p0 is the overall parity bit.
- Syndrome s[3:0] is the XOR of the indices of all set bits in positions 1..15. P is the XOR of all 16 bits.
- s=0 and P=0: no error; flags=00.
- P=1: single error at position s (s=0 means p0); flip that bit; flags=01; increment `n_single`.
- s≠0 and P=0: double error; the data is passed uncorrected; flags=10; increment `n_double`.
- Output high byte = {flags[1:0], 3'b000, d11, d10, d9}. Output low byte = d8..d1.
- FSM states: IDLE, RD_LO, RD_HI, FIX, WR_LO, WR_HI, DONE.
- IDLE → RD_LO on `start`. On that transition, clear the index and both counters and drop `done`.
- RD_LO: address SRC_BASE+2i; latch the low byte.
- RD_HI: address SRC_BASE+2i+1; latch the high byte.
- FIX: compute and register the corrected word and flags; update the counters.
- WR_LO: address DST_BASE+2i; `mem_wr_en`=1; write the low byte.
- WR_HI: address DST_BASE+2i+1; `mem_wr_en`=1; write the high byte. Then go to RD_LO with i+1, or to DONE if i=N_WORDS-1.
- DONE: `done`=1. Go to RD_LO (new run) when `start`=1; otherwise hold.
- `start` in RD_LO..WR_HI is ignored. There is no restart mid-run.
- Address arithmetic is modulo 2^AW (wraps silently). The counters saturate at 63.

## Timing
- Reset values: state=IDLE, `done`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0, `n_single`=0, `n_double`=0.
- Each word takes exactly 5 cycles. With `start` accepted at edge k, `done` is high after edge k+5·N_WORDS+1 (76 cycles for the defaults).
- Per word, exactly two write strobes are issued, low byte first, each one cycle wide. No writes occur in IDLE, FIX, or DONE.
- `mem_addr` is 0 whenever no access is in progress.
- Reset asserted mid-run: the engine is in IDLE within the same cycle with `mem_wr_en` low. Bytes already written remain in memory. No partial write of the current byte occurs after reset.
- `start` held high continuously: each run is followed by one DONE cycle, and then a new run starts.

## Test plan
- Clean run: all 15 source words are 0x55A5 (message 11'b01010101010) → every destination pair is hi=0x02, lo=0xAA; `n_single`=0, `n_double`=0; `done` rises 76 cycles after `start`.
- Single error: word i is 0x55A5 XOR (1<<i) for i=0..14 → all outputs are hi=0x42, lo=0xAA; `n_single`=15. Separately, 0x55A4 (p0 flipped) → hi=0x42, lo=0xAA.
- Double error: 0x57AD (bits 9 and 3 flipped) → hi=0x82, lo=0xBB (raw data); `n_double`=1; no correction is applied.
- Mixed run: clean, single, and double words interleaved → per-word flags are correct; counters match the injected counts; source bytes 30..59 are unchanged.
- Protocol: pulse `start` again mid-run → ignored, with exactly 30 write strobes total. Assert `reset` low at cycle 20 → `done`=0 and writes stop; a fresh `start` then completes the full run correctly.
- Parameter override: SRC_BASE=64, DST_BASE=128, N_WORDS=1 → 5-cycle run; only addresses 128 and 129 are written.
